// File: rtl/regfile_read_8x16_pkg.sv
// Shared constants and types for the 8x16 register file read port.
//
// Contents:
//   RF_WIDTH     data width of each register and read result
//   RF_ADDR_W    register address width
//   RF_DEPTH     number of registers (2**RF_ADDR_W)
//   RESET_VALUE  value every register takes on reset
//   rf_data_t    one register / operand word
//   rf_addr_t    one register address
//   addr_hit     write-port match helper: enable qualified address compare
package regfile_read_8x16_pkg;

  localparam int unsigned RF_WIDTH  = 16;
  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_DEPTH  = 1 << RF_ADDR_W;

  localparam logic [RF_WIDTH-1:0] RESET_VALUE = 16'h0000;

  typedef logic [RF_WIDTH-1:0]  rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  // True when an enabled write targets the given register.
  function automatic logic addr_hit(logic en, rf_addr_t wr_addr, rf_addr_t addr);
    return en && (wr_addr == addr);
  endfunction

endpackage

// File: rtl/rf_operand_sel.sv
// Source-operand selector: one 8:1 read mux over the register array plus the
// same-cycle write bypass, so an operand captured on the edge that also
// writes its register sees the new value rather than the stale one.
//
// Ports:
//   regs     in   all registers, flattened; register i at [i*WIDTH +: WIDTH]
//   rd_addr  in   register to read
//   wr_en    in   write port enable
//   wr_addr  in   write port address
//   wr_data  in   write port data
//   operand  out  selected value (bypassed write data on an address match)
module rf_operand_sel
  import regfile_read_8x16_pkg::*;
#(
  parameter int unsigned WIDTH      = RF_WIDTH,
  parameter int unsigned DEPTH_LOG2 = RF_ADDR_W
) (
  input  logic [WIDTH*(1<<DEPTH_LOG2)-1:0] regs,
  input  logic [DEPTH_LOG2-1:0]            rd_addr,
  input  logic                             wr_en,
  input  logic [DEPTH_LOG2-1:0]            wr_addr,
  input  logic [WIDTH-1:0]                 wr_data,
  output logic [WIDTH-1:0]                 operand
);

  logic [WIDTH-1:0] array_val;
  logic             bypass;

  // Plain read of the stored value.
  always_comb begin
    array_val = regs[WIDTH*int'(rd_addr) +: WIDTH];
  end

  assign bypass = wr_en && (wr_addr == rd_addr);

  always_comb begin
    operand = bypass ? wr_data : array_val;
  end

endmodule

// File: rtl/regfile_read_8x16.sv
// 8-entry x 16-bit register file with one write port and a two-operand
// registered read port, used as the decode-stage source-operand reader.
//
// A read request is accepted on reqValid & reqReady; both operands are
// registered and presented one cycle later with rspValid. A response that is
// not consumed is held, and any write to a held register while stalled is
// folded into the held operand so the consumer never sees stale data.
//
// Ports:
//   clk       in   system clock, all state on rising edge
//   rst       in   synchronous active-high reset
//   wrEn      in   write enable
//   wrAddr    in   register written when wrEn=1
//   wrData    in   write data
//   reqValid  in   read request present
//   reqReady  out  read port can accept a request this cycle
//   rdAddr1   in   operand 1 register address
//   rdAddr2   in   operand 2 register address
//   rspValid  out  rspData1/rspData2 hold a valid result
//   rspReady  in   consumer accepts the result this cycle
//   rspData1  out  operand 1 result
//   rspData2  out  operand 2 result
module regfile_read_8x16
  import regfile_read_8x16_pkg::*;
#(
  parameter int unsigned WIDTH      = RF_WIDTH,
  parameter int unsigned DEPTH_LOG2 = RF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEn,
  input  logic [DEPTH_LOG2-1:0] wrAddr,
  input  logic [WIDTH-1:0]      wrData,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [DEPTH_LOG2-1:0] rdAddr1,
  input  logic [DEPTH_LOG2-1:0] rdAddr2,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [WIDTH-1:0]      rspData1,
  output logic [WIDTH-1:0]      rspData2
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]       regs_q [DEPTH];
  logic [WIDTH*DEPTH-1:0] regs_flat;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= WIDTH'(RESET_VALUE);
      end
    end else if (wrEn) begin
      regs_q[wrAddr] <= wrData;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Operand selection (read mux + same-cycle bypass)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;

  rf_operand_sel #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sel1 (
    .regs    (regs_flat),
    .rd_addr (rdAddr1),
    .wr_en   (wrEn),
    .wr_addr (wrAddr),
    .wr_data (wrData),
    .operand (operand1)
  );

  rf_operand_sel #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sel2 (
    .regs    (regs_flat),
    .rd_addr (rdAddr2),
    .wr_en   (wrEn),
    .wr_addr (wrAddr),
    .wr_data (wrData),
    .operand (operand2)
  );

  // ---------------------------------------------------------------------------
  // Response register, held addresses and handshake
  // ---------------------------------------------------------------------------
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]      rsp_data1_q, rsp_data1_d;
  logic [WIDTH-1:0]      rsp_data2_q, rsp_data2_d;
  logic [DEPTH_LOG2-1:0] h_addr1_q, h_addr1_d;
  logic [DEPTH_LOG2-1:0] h_addr2_q, h_addr2_d;

  logic req_ready;
  logic accept;
  logic stall;
  logic stall_hit1;
  logic stall_hit2;

  assign req_ready = !rsp_valid_q || rspReady;
  assign accept    = reqValid && req_ready;
  assign stall     = rsp_valid_q && !rspReady;

  // A write landing on a held register refreshes that operand in place.
  assign stall_hit1 = stall && wrEn && (wrAddr == h_addr1_q);
  assign stall_hit2 = stall && wrEn && (wrAddr == h_addr2_q);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;
    h_addr1_d   = h_addr1_q;
    h_addr2_d   = h_addr2_q;

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data1_d = operand1;
      rsp_data2_d = operand2;
      h_addr1_d   = rdAddr1;
      h_addr2_d   = rdAddr2;
    end else begin
      if (rspReady) begin
        rsp_valid_d = 1'b0;
      end
      if (stall_hit1) begin
        rsp_data1_d = wrData;
      end
      if (stall_hit2) begin
        rsp_data2_d = wrData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
      h_addr1_q   <= '0;
      h_addr2_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
      h_addr1_q   <= h_addr1_d;
      h_addr2_q   <= h_addr2_d;
    end
  end

  assign reqReady = req_ready;
  assign rspValid = rsp_valid_q;
  assign rspData1 = rsp_data1_q;
  assign rspData2 = rsp_data2_q;

endmodule

// File: doc/regfile_read_8x16.md
Name: regfile_read_8x16

Overview:
- 8-entry x 16-bit register file with one write port and a two-operand registered read port.
- Serves as the decode-stage source-operand reader of the pipelined processor.
- Read requests use a valid/ready handshake. A stalled result is held, and kept coherent with later writes to the same register.
- Same-cycle write-to-read bypass; result appears one cycle after request acceptance.

Parameters:
- WIDTH, 16, data width of each register and read result
- DEPTH_LOG2, 3, address width; DEPTH = 8 registers

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- wrEn  input  1  write enable, sampled at rising edge
- wrAddr  input  3  register written when wrEn=1
- wrData  input  16  write data
- reqValid  input  1  read request present
- reqReady  output  1  read port can accept a request this cycle
- rdAddr1  input  3  operand 1 register address
- rdAddr2  input  3  operand 2 register address
- rspValid  output  1  rspData1/rspData2 hold a valid result
- rspReady  input  1  consumer accepts result this cycle
- rspData1  output  16  operand 1 result
- rspData2  output  16  operand 2 result

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: while rst=1 at an edge, all 8 registers clear to 0x0000, and rspValid, rspData1, rspData2 clear to 0.
- reqReady during and after reset: reqReady is combinational; with rspValid=0 it is 1 during and after reset.
- Reset mid-operation: a pending or held result is discarded (rspValid=0 next cycle), and any wrEn in the same cycle is ignored.
- Write: at an edge with wrEn=1 and rst=0, reg[wrAddr] <= wrData. All 8 registers are writable; none is hardwired.
- Handshake: reqReady = !rspValid | rspReady. A request is accepted at an edge where reqValid & reqReady.
- Latency: accepted request -> rspValid=1 with data on the next cycle. Back-to-back acceptance is possible every cycle when rspReady=1.
- Captured operand value, per operand: if wrEn and wrAddr==rdAddrN, capture wrData (bypass); else capture reg[rdAddrN].
- Both operands same address: both outputs get identical values.
- Response register and hold address:
  - rspValid next = accept ? 1 : (rspReady ? 0 : rspValid).
  - Held address registers hAddr1/hAddr2 latch rdAddr1/rdAddr2 on accept.
- Stall coherence: while rspValid=1 and the response is not consumed, a write with wrAddr==hAddrN replaces rspDataN with wrData at that edge. Applies to each operand independently, or both if the addresses match.
- Write vs. consume: write and consume in the same cycle, with no new accept, means the result leaves and the register updates; no other effect.
- Write vs. new accept: write, consume and new accept in the same cycle means the new accept uses the bypass rule.
- Stable outputs: rspData1/rspData2 are stable when not accepting or stall-updating.
- Idle response: rspData values are don't-care when rspValid=0, but are left at their last value (no clearing except reset).
- Address width: no out-of-range addresses exist (3-bit). WIDTH arithmetic is none; pure storage and muxing.

Decomposition:
- Shared package constants: RF_WIDTH=16, RF_ADDR_W=3, RF_DEPTH=8, RESET_VALUE=16'h0000.
- Natural sub-module rf_operand_sel, instantiated twice. It combines an 8:1 16-bit read mux with the bypass compare against wrEn/wrAddr/wrData.
- The top holds the register array, the response register, held addresses and the handshake.

Test Plan:
- Reset then read: rst=1 for 2 cycles; request rdAddr1=3, rdAddr2=7 -> next cycle rspValid=1, rspData1=0x0000, rspData2=0x0000, reqReady=1 throughout.
- Write then read, and bypass: write R2=0xBEEF; next cycle request rdAddr1=2 -> rspData1=0xBEEF. Same-cycle write R5=0x1234 with request rdAddr2=5 -> rspData2=0x1234.
- Stall hold with coherence: R4=0x0011; request rdAddr1=4, rdAddr2=4 with rspReady=0. reqReady drops to 0 and data is held 3 cycles. Write R4=0x00AA during the stall -> both outputs become 0x00AA next cycle; raise rspReady -> rspValid=0 the cycle after.
- Streaming: rspReady=1, requests every cycle for R0..R7 preloaded 0x1000+i -> rspData1 sequence 0x1000..0x1007 on consecutive cycles, no bubbles.
- Reset mid-stall: response held with rspValid=1, assert rst with wrEn=1 to R1=0xFFFF -> next cycle rspValid=0; a read of R1 returns 0x0000.
